// File: rtl/imm_pkg.sv
// Shared types and constants for the decode->execute immediate generator.
// Optional macro IMM_EXTEND_ZIMM_EN enables the CSR zimm encoding (Z_T).
package imm_pkg;

    localparam int PAYLOAD_W = 25;

    typedef enum logic [2:0] {
        I_T = 3'b000,
        S_T = 3'b001,
        B_T = 3'b010,
        J_T = 3'b011,
        U_T = 3'b100,
        Z_T = 3'b101
    } imm_src_e;

    // Result for any unsupported select: zero immediate, error flagged.
    localparam logic [63:0] ILLEGAL_IMM = 64'd0;
    localparam logic        ILLEGAL_ERR = 1'b1;

endpackage

// File: rtl/imm_extend_comb.sv
// Purpose: combinational RISC-V immediate extraction/extension; zimm only with IMM_EXTEND_ZIMM_EN.
// Latency: 0 cycles (pure logic).
// Backpressure: none, no state.
module imm_extend_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]           imm_src,
    input  logic [PAYLOAD_W-1:0] data,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    always_comb begin
        imm = XLEN'(ILLEGAL_IMM);
        err = 1'b0;
        case (imm_src_e'(imm_src))
            I_T: imm = XLEN'($signed(data[24:13]));
            S_T: imm = XLEN'($signed({data[24:18], data[4:0]}));
            B_T: imm = XLEN'($signed({data[24], data[0], data[23:18], data[4:1], 1'b0}));
            J_T: imm = XLEN'($signed({data[24], data[12:5], data[13], data[23:14], 1'b0}));
            // Signed cast sign-extends from bit 31 when XLEN is 64.
            U_T: imm = XLEN'($signed({data[24:5], 12'b0}));
`ifdef IMM_EXTEND_ZIMM_EN
            Z_T: imm = XLEN'(data[12:8]);
`endif
            default: begin
                imm = XLEN'(ILLEGAL_IMM);
                err = ILLEGAL_ERR;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Purpose: registered immediate generator with tag passthrough and 2-entry skid buffer (zimm via IMM_EXTEND_ZIMM_EN).
// Latency: 1 cycle from accept to out_valid when the main register is free or popping; 1/cycle throughput.
// Backpressure: in_ready = !skid_valid (registered); flush clears both entries, rst clears everything.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_imm_src,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t     new_ent;
    entry_t     main_ent;
    entry_t     skid_ent;
    logic       main_vld;
    logic       skid_vld;
    logic       accept;
    logic       pop;

    imm_extend_comb #(.XLEN(XLEN)) u_ext (
        .imm_src (in_imm_src),
        .data    (in_data),
        .imm     (new_ent.imm),
        .err     (new_ent.err)
    );
    assign new_ent.tag = in_tag;

    assign in_ready  = !skid_vld;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_vld;
    assign pop       = main_vld && out_ready;

    assign out_imm = main_ent.imm;
    assign out_tag = main_ent.tag;
    assign out_err = main_ent.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_ent <= '0;
            skid_ent <= '0;
        end else if (flush) begin
            // Data registers hold; a same-cycle accept is dropped.
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (pop) begin
            if (skid_vld) begin
                main_ent <= skid_ent;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_ent <= new_ent;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!main_vld) begin
                main_ent <= new_ent;
                main_vld <= 1'b1;
            end else begin
                skid_ent <= new_ent;
                skid_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed literal checks plus randomized traffic against a queue model.
// A second XLEN=64 instance shares the stimulus to cover 64-bit extension.
module tb_imm_extend_pipe;

    localparam int TAG_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_imm_src;
    logic [24:0]       in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    logic              in_ready64;
    logic              out_valid64;
    logic [63:0]       out_imm64;
    logic [TAG_W-1:0]  out_tag64;
    logic              out_err64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_src(in_imm_src), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_imm_src(in_imm_src), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: immediate as a signed integer value, then taken modulo 2^64.
    function automatic logic [64:0] ref_ext(input logic [2:0] src, input logic [24:0] d);
        longint v;
        logic   e;
        v = 0;
        e = 1'b0;
        case (src)
            3'd0: begin v = longint'(d[24:13]); if (v >= 2048) v -= 4096; end
            3'd1: begin v = longint'(d[24:18]) * 32 + longint'(d[4:0]); if (v >= 2048) v -= 4096; end
            3'd2: begin
                v = longint'(d[24]) * 4096 + longint'(d[0]) * 2048
                  + longint'(d[23:18]) * 32 + longint'(d[4:1]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = longint'(d[24]) * (1 << 20) + longint'(d[12:5]) * (1 << 12)
                  + longint'(d[13]) * (1 << 11) + longint'(d[23:14]) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            3'd4: begin
                v = longint'(d[24:5]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
`ifdef IMM_EXTEND_ZIMM_EN
            3'd5: v = longint'(d[12:8]);
`endif
            default: begin v = 0; e = 1'b1; end
        endcase
        return {e, 64'(v)};
    endfunction

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    ent_t q[$];
    bit   started = 0;

    // Model: occupancy queue of up to two finished results.
    always @(posedge clk) begin
        logic [64:0] r;
        ent_t        e;
        bit          acc;
        started = 1;
        if (rst || flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                r = ref_ext(in_imm_src, in_data);
                e.imm = r[63:0];
                e.err = r[64];
                e.tag = in_tag;
                q.push_back(e);
            end
        end
    end

    bit               held = 0;
    logic [31:0]      h_imm;
    logic [TAG_W-1:0] h_tag;
    logic             h_err;

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_imm", 64'(out_imm), 64'(q[0].imm[31:0]));
                chk("out_imm64", out_imm64, q[0].imm);
                chk("out_tag", 64'(out_tag), 64'(q[0].tag));
                chk("out_err", 64'(out_err), 64'(q[0].err));
            end
            if (held) begin
                chk("stable_imm", 64'(out_imm), 64'(h_imm));
                chk("stable_tag", 64'(out_tag), 64'(h_tag));
                chk("stable_err", 64'(out_err), 64'(h_err));
            end
            held  = out_valid && !out_ready && !flush && !rst;
            h_imm = out_imm;
            h_tag = out_tag;
            h_err = out_err;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] src, input logic [24:0] d, input logic [TAG_W-1:0] t);
        in_valid   = 1'b1;
        in_imm_src = src;
        in_data    = d;
        in_tag     = t;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm_src = 3'd0;
        in_data = '0; in_tag = '0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // addi x1,x0,-1
        offer(3'd0, 25'h1FFE001, 32'hA);
        cyc();
        chk("i_valid", 64'(out_valid), 64'd1);
        chk("i_imm", 64'(out_imm), 64'hFFFF_FFFF);
        chk("i_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("i_err", 64'(out_err), 64'd0);
        offer(3'd2, 25'h1FC001D, 32'hB);
        cyc();
        chk("b_imm", 64'(out_imm), 64'hFFFF_FFFC);
        offer(3'd4, {20'h12345, 5'd1}, 32'hC);
        cyc();
        chk("u_imm", 64'(out_imm), 64'h1234_5000);
        offer(3'd4, {20'h80000, 5'd0}, 32'hD);
        cyc();
        chk("u_imm32", 64'(out_imm), 64'h8000_0000);
        chk("u_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        in_valid = 1'b0;
        cyc();

        // Backpressure ordering
        out_ready = 1'b0;
        offer(3'd0, 25'h0012345, 32'd1);
        cyc();
        chk("bp_ready1", 64'(in_ready), 64'd1);
        offer(3'd1, 25'h1A5A5A5, 32'd2);
        cyc();
        chk("bp_ready2", 64'(in_ready), 64'd0);
        chk("bp_tag_a", 64'(out_tag), 64'd1);
        offer(3'd3, 25'h0ABCDEF, 32'd3);
        cyc();
        chk("bp_tag_b", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        cyc();
        chk("bp_tag_2", 64'(out_tag), 64'd2);
        cyc();
        chk("bp_tag_3", 64'(out_tag), 64'd3);
        in_valid = 1'b0;
        cyc();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush with both entries full, then with an accept in flight
        out_ready = 1'b0;
        offer(3'd0, 25'h1, 32'd4); cyc();
        offer(3'd0, 25'h2, 32'd5); cyc();
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        offer(3'd0, 25'h3, 32'd6);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        offer(3'd0, 25'h4, 32'd7); cyc();
        flush = 1'b1;
        offer(3'd0, 25'h5, 32'd8); cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drop_a", 64'(out_valid), 64'd0);
        cyc();
        chk("fl_drop_b", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // Illegal and zimm encodings
        offer(3'd7, 25'h1FFFFFF, 32'hE);
        cyc();
        chk("ill_imm", 64'(out_imm), 64'd0);
        chk("ill_err", 64'(out_err), 64'd1);
        offer(3'd5, 25'h0001F00, 32'hF);
        cyc();
`ifdef IMM_EXTEND_ZIMM_EN
        chk("z_imm", 64'(out_imm), 64'h1F);
        chk("z_err", 64'(out_err), 64'd0);
`else
        chk("z_imm", 64'(out_imm), 64'd0);
        chk("z_err", 64'(out_err), 64'd1);
`endif
        in_valid = 1'b0;
        cyc();

        // Reset mid-stream with both entries full
        out_ready = 1'b0;
        offer(3'd4, 25'h1234567, 32'h11); cyc();
        offer(3'd2, 25'h0765432, 32'h12); cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_imm", 64'(out_imm), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        offer(3'd0, 25'h1FFE001, 32'd9);
        cyc();
        in_valid = 1'b0;
        chk("mrst_first_valid", 64'(out_valid), 64'd1);
        chk("mrst_first_tag", 64'(out_tag), 64'd9);
        chk("mrst_first_imm", 64'(out_imm), 64'hFFFF_FFFF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(3) != 0);
            in_imm_src = 3'($urandom_range(7));
            in_data    = 25'($urandom);
            in_tag     = $urandom;
            out_ready  = ($urandom_range(2) != 0);
            flush      = ($urandom_range(39) == 0);
            rst        = ($urandom_range(249) == 0);
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("final_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
